// File: rtl/store_lane_unit.sv
// Store lane unit: narrows a register value to byte/half/word, places it on the
// data-memory byte lanes with byte enables, and splits word-crossing stores in two.
`timescale 1ns/1ps
module store_lane_unit #(
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a raised valid and its payload hold until that edge (reset excepted).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BEAT0  = 2'd1;
  localparam logic [1:0] ST_BEAT1  = 2'd2;
  localparam logic [1:0] ST_REJECT = 2'd3;

  logic [1:0]  state;
  logic        b1_need;
  logic [31:0] b1_addr;
  logic [31:0] b1_wdata;
  logic [3:0]  b1_be;

  logic        accept;
  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [31:0] size_data;
  logic [7:0]  win_mask;
  logic [63:0] win_data;
  logic [31:0] beat0_addr;
  logic        need_b1;
  logic        reject;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // Place the narrowed value into an 8-lane window spanning two memory words.
  always_comb begin
    off        = req_addr[1:0];
    size_mask  = 4'b0000;
    size_data  = 32'h0;
    case (req_size)
      2'b00: begin
        size_mask = 4'b0001;
        size_data = {24'h0, req_data[7:0]};
      end
      2'b01: begin
        size_mask = 4'b0011;
        size_data = {16'h0, req_data[15:0]};
      end
      2'b10: begin
        size_mask = 4'b1111;
        size_data = req_data;
      end
      default: begin
        size_mask = 4'b0000;
        size_data = 32'h0;
      end
    endcase
    win_mask   = {4'b0000, size_mask} << off;
    win_data   = {32'h0, size_data} << {off, 3'b000};
    beat0_addr = {req_addr[31:2], 2'b00};
    need_b1    = |win_mask[7:4];
    reject     = (req_size == 2'b11) || (need_b1 && (ALLOW_MISALIGNED == 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
      b1_need   <= 1'b0;
      b1_addr   <= 32'h0;
      b1_wdata  <= 32'h0;
      b1_be     <= 4'b0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (reject) begin
              state <= ST_REJECT;
              err   <= 1'b1;
            end else begin
              state     <= ST_BEAT0;
              mem_valid <= 1'b1;
              mem_addr  <= beat0_addr;
              mem_be    <= win_mask[3:0];
              mem_wdata <= win_data[31:0];
              b1_need   <= need_b1;
              b1_addr   <= beat0_addr + 32'd4;
              b1_be     <= win_mask[7:4];
              b1_wdata  <= win_data[63:32];
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
            if (b1_need) begin
              state     <= ST_BEAT1;
              mem_addr  <= b1_addr;
              mem_be    <= b1_be;
              mem_wdata <= b1_wdata;
            end else begin
              state     <= ST_IDLE;
              mem_valid <= 1'b0;
              mem_addr  <= 32'h0;
              mem_be    <= 4'b0000;
              mem_wdata <= 32'h0;
              done      <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            done      <= 1'b1;
          end
        end
        ST_REJECT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_lane_unit.sv
// Randomized self-checking bench for store_lane_unit against a byte-by-byte store model.
`timescale 1ns/1ps
module tb_store_lane_unit;

  localparam int W = 69;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  logic        req_valid_nm;
  logic        req_ready_nm;
  logic        mem_valid_nm;
  logic        mem_ready_nm;
  logic [31:0] mem_addr_nm;
  logic [31:0] mem_wdata_nm;
  logic [3:0]  mem_be_nm;
  logic        done_nm;
  logic        err_nm;

  // Expected beats packed as {addr, be, wdata}, widened by one bit for the valid flag.
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;
  bit           rej_v;
  int           nb_v;

  store_lane_unit #(.ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .done(done), .err(err)
  );

  store_lane_unit #(.ALLOW_MISALIGNED(0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_nm), .req_ready(req_ready_nm),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid_nm), .mem_ready(mem_ready_nm),
    .mem_addr(mem_addr_nm), .mem_wdata(mem_wdata_nm), .mem_be(mem_be_nm),
    .done(done_nm), .err(err_nm)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the stored bytes one at a time, assigning each to the
  // memory word it lands in; queue the resulting beats unless rejected.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input bit allow, output bit rej, output int nb);
    int          nbytes;
    logic [31:0] ba;
    logic [31:0] w_addr [2];
    logic [3:0]  w_be   [2];
    logic [31:0] w_data [2];
    int          idx;
    int          lane;
    nbytes    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    w_addr[0] = a & 32'hFFFF_FFFC;
    w_addr[1] = w_addr[0] + 32'd4;
    for (int i = 0; i < 2; i++) begin
      w_be[i]   = 4'b0000;
      w_data[i] = 32'h0;
    end
    for (int k = 0; k < nbytes; k++) begin
      ba   = a + k;
      idx  = ((ba & 32'hFFFF_FFFC) == w_addr[0]) ? 0 : 1;
      lane = int'(ba % 4);
      w_be[idx][lane]           = 1'b1;
      w_data[idx][8*lane +: 8]  = d[8*k +: 8];
    end
    nb  = (w_be[1] != 4'b0000) ? 2 : 1;
    rej = (sz == 2'd3) || (nb == 2 && !allow);
    if (!rej)
      for (int i = 0; i < nb; i++)
        exp_q.push_back({1'b1, w_addr[i], w_be[i], w_data[i]});
  endtask

  // Drives one store through the main DUT and checks every cycle until done/err.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int st0, input int st1);
    int           waitc;
    int           st;
    logic [W-1:0] exp_b;
    model(a, d, sz, 1'b1, rej_v, nb_v);
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_accept", W'(req_ready), W'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    if (rej_v) begin
      @(negedge clk);
      check("rej_err_pulse", W'({err, mem_valid, done, req_ready}), W'(4'b1000));
      @(posedge clk); #1;
      @(negedge clk);
      check("rej_back_idle", W'({err, mem_valid, done, req_ready}), W'(4'b0001));
    end else begin
      for (int b = 0; b < nb_v; b++) begin
        st    = (b == 0) ? st0 : st1;
        exp_b = exp_q.pop_front();
        mem_ready = 1'b0;
        for (int s = 0; s < st; s++) begin
          @(negedge clk);
          check("beat_stalled", {mem_valid, mem_addr, mem_be, mem_wdata}, exp_b);
          @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("beat", {mem_valid, mem_addr, mem_be, mem_wdata}, exp_b);
        check("no_pulse_mid_store", W'({done, err, req_ready}), W'(3'b000));
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
      @(negedge clk);
      check("done_pulse", W'({done, err, req_ready, mem_valid}), W'(4'b1010));
    end
  endtask

  initial begin
    logic [W-1:0] exp_b;
    logic [31:0]  a;
    logic [1:0]   sz;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_valid_nm = 1'b0;
    mem_ready    = 1'b0;
    mem_ready_nm = 1'b1;
    req_addr     = 32'h0;
    req_data     = 32'h0;
    req_size     = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", W'({req_ready, mem_valid, done, err, mem_be}), W'(8'b1000_0000));
    check("reset_mem_bus", W'({mem_addr, mem_wdata}), W'(64'h0));

    // Directed cases, issued back to back
    run_store(32'h0000_1002, 32'hAABB_CCDD, 2'b00, 0, 0);
    run_store(32'h0000_2000, 32'h1234_5678, 2'b10, 3, 0);
    run_store(32'h0000_3003, 32'h0000_BEEF, 2'b01, 0, 0);
    run_store(32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 1, 2);
    run_store(32'h0000_5000, 32'hDEAD_BEEF, 2'b11, 0, 0);
    run_store(32'h0000_6001, 32'h8765_4321, 2'b01, 0, 0);

    // Randomized stores
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_store(a, $urandom, sz, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Non-splitting instance: aligned word completes, crossing half is rejected
    model(32'h0000_4000, 32'hCAFE_F00D, 2'b10, 1'b0, rej_v, nb_v);
    req_addr = 32'h0000_4000; req_data = 32'hCAFE_F00D; req_size = 2'b10;
    req_valid_nm = 1'b1;
    @(posedge clk); #1;
    req_valid_nm = 1'b0;
    @(negedge clk);
    exp_b = exp_q.pop_front();
    check("nm_word_beat", {mem_valid_nm, mem_addr_nm, mem_be_nm, mem_wdata_nm}, exp_b);
    @(posedge clk); #1;
    @(negedge clk);
    check("nm_word_done", W'({done_nm, err_nm, req_ready_nm}), W'(3'b101));
    model(32'h0000_4003, 32'h0000_BEEF, 2'b01, 1'b0, rej_v, nb_v);
    req_addr = 32'h0000_4003; req_data = 32'h0000_BEEF; req_size = 2'b01;
    req_valid_nm = 1'b1;
    @(posedge clk); #1;
    req_valid_nm = 1'b0;
    @(negedge clk);
    check("nm_cross_err", W'({err_nm, mem_valid_nm, done_nm, req_ready_nm}), W'(4'b1000));
    @(posedge clk); #1;
    @(negedge clk);
    check("nm_cross_idle", W'({err_nm, mem_valid_nm, done_nm, req_ready_nm}), W'(4'b0001));

    // Reset while the second beat of a split store is stalled
    model(32'h0000_7003, 32'h0000_A55A, 2'b01, 1'b1, rej_v, nb_v);
    req_addr = 32'h0000_7003; req_data = 32'h0000_A55A; req_size = 2'b01;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    exp_b = exp_q.pop_front();
    check("rst_case_beat0", {mem_valid, mem_addr, mem_be, mem_wdata}, exp_b);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    exp_b = exp_q.pop_front();
    check("rst_case_beat1_stall", {mem_valid, mem_addr, mem_be, mem_wdata}, exp_b);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_valid", W'({mem_valid, mem_be, done, err}), W'(7'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_idle_no_done", W'({done, err, req_ready, mem_valid}), W'(4'b0010));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_lane_unit.md
Name: store_lane_unit

Overview:
- Store-side partner of the immediate/load extend path. It narrows a 32-bit register value to byte, halfword or word, places it on the correct data-memory byte lanes and generates byte enables.
- Stores that straddle a word boundary are split into two word-aligned memory beats.
- Sits between the datapath store request and the data memory write port. Both sides use a valid/ready handshake.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing stores into two beats; 0 = reject them with err and perform no write.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_addr  input  32  byte address of the store.
- req_data  input  32  register value; only the low bytes selected by req_size are used.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- mem_valid  output  1  memory write beat valid.
- mem_ready  input  1  memory accepts the beat.
- mem_addr  output  32  word-aligned beat address; bits [1:0] are always 00.
- mem_wdata  output  32  lane-aligned write data.
- mem_be  output  4  byte enables; bit i enables lane i (bits 8i+7:8i).
- done  output  1  one-cycle pulse when a store fully completes.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - req_ready = 1 once released (it follows IDLE).
  - mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, done = 0, err = 0.
  - Any in-flight store is discarded without completing.
- Acceptance:
  - A request is accepted when req_valid & req_ready at a rising edge.
  - req_* are sampled at that edge only; later changes are ignored.
- Lane computation at accept, with off = req_addr[1:0]:
  - size mask m = 0001 (byte), 0011 (half), 1111 (word).
  - 8-bit window mask W = m << off.
  - 64-bit window data D = zero-extended req_data << (8*off).
  - Beat0: addr = {req_addr[31:2], 00}, be = W[3:0], wdata = D[31:0].
  - Beat1 is needed iff W[7:4] != 0: addr = beat0 addr + 4 (wraps modulo 2^32), be = W[7:4], wdata = D[63:32].
  - Byte lanes with a zero enable carry 0 in mem_wdata.
- Rejection, with no memory beat, err pulses the cycle after accept, and the unit returns to IDLE:
  - req_size == 11;
  - Beat1 needed and ALLOW_MISALIGNED = 0.
- FSM states: IDLE, BEAT0, BEAT1, REJECT.
  - IDLE: on accept, go to REJECT if rejected, otherwise to BEAT0.
  - BEAT0: mem_valid = 1. On mem_ready, go to BEAT1 if beat1 is needed, otherwise to IDLE with done pulsing that next cycle.
  - BEAT1: mem_valid = 1. On mem_ready, go to IDLE with done pulsing that next cycle.
  - REJECT: err = 1 for one cycle, then go to IDLE.
- Timing:
  - All outputs are registered.
  - First beat is valid the cycle after accept.
  - Minimum latency: single-beat store = 2 cycles from accept to done; split store = 3 cycles.
- Handshake:
  - While mem_valid & !mem_ready, mem_addr, mem_wdata and mem_be hold stable and mem_valid stays high.
  - mem_valid never drops without a handshake, except on reset.
  - Back-to-back: done and req_ready are both high in the same cycle, so a new request can be accepted that cycle.
- done and err are never high together, and never high outside the single cycle after completion or rejection.

Test Plan:
- Byte store, addr 0x1002, data 0xAABBCCDD, size 00, mem_ready = 1 → one beat: mem_addr 0x1000, be 0100, wdata 0x00DD0000; done 2 cycles after accept.
- Aligned word, addr 0x2000, data 0x12345678 → one beat: be 1111, wdata 0x12345678. Hold mem_ready low 3 cycles → outputs stable throughout, done after the handshake.
- Misaligned half, addr 0x3003, data 0x0000BEEF → beat0: addr 0x3000, be 1000, wdata 0xEF000000; beat1: addr 0x3004, be 0001, wdata 0x000000BE; done follows beat1.
- Misaligned word, addr 0xFFFFFFFE, data 0x11223344 → beat0: addr 0xFFFFFFFC, be 1100, wdata 0x33440000; beat1: addr 0x00000000, be 0011, wdata 0x00001122.
- size 11, and a separate run with ALLOW_MISALIGNED = 0 plus a half store at offset 3 → err pulses once, mem_valid stays 0, req_ready returns high.
- rst_n low while BEAT1 is stalled → mem_valid drops immediately; after release the unit is in IDLE with req_ready = 1 and no done pulse.
